countdown_counter: RTL and testbench

Loadable 4-digit BCD down-counter: the count-down counterpart of the chronometer's up-counter, in the same digit format. Digit ranges: d0 units 0-9, d1 0-9, d2 0-5, d3 0-9. Decrements one step per prescaled tick from a loaded preset down to 0000, then raises a single-cycle done pulse. Used as the kitchen-timer/alarm companion to the chronometer.

---
 rtl/countdown_counter.sv | 99 +++++++++
 tb/tb_countdown_counter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/countdown_counter.sv
// countdown_counter: loadable 4-digit BCD down-counter with prescaler, pause and done pulse
module countdown_counter #(
   parameter int PRESCALE = 1,
   parameter int PS_W = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       load,
   input  logic [3:0] load_0,
   input  logic [3:0] load_1,
   input  logic [3:0] load_2,
   input  logic [3:0] load_3,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] counter_0,
   output logic [3:0] counter_1,
   output logic [3:0] counter_2,
   output logic [3:0] counter_3,
   output logic       running,
   output logic       done
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] d0_q, d1_q, d2_q, d3_q, d0_d, d1_d, d2_d, d3_d;
   logic [3:0] n0, n1, n2, n3;
   logic [PS_W-1:0] ps_q, ps_d;
   logic done_q, done_d, b0, b1, b2, zero, next_zero, tick;
   always_comb begin
      b0 = d0_q == 4'd0;
      b1 = b0 && d1_q == 4'd0;
      b2 = b1 && d2_q == 4'd0;
      n0 = b0 ? 4'd9 : d0_q - 4'd1;
      n1 = b0 ? (d1_q == 4'd0 ? 4'd9 : d1_q - 4'd1) : d1_q;
      n2 = b1 ? (d2_q == 4'd0 ? 4'd5 : d2_q - 4'd1) : d2_q;
      n3 = b2 ? d3_q - 4'd1 : d3_q;
      zero = {d3_q, d2_q, d1_q, d0_q} == 16'h0000;
      next_zero = {n3, n2, n1, n0} == 16'h0000;
      tick = ps_q == PS_W'(PRESCALE - 1);
   end
   always_comb begin
      state_d = state_q;
      ps_d = ps_q;
      done_d = 1'b0;
      d0_d = d0_q;
      d1_d = d1_q;
      d2_d = d2_q;
      d3_d = d3_q;
      if (load) begin
         d0_d = load_0 > 4'd9 ? 4'd9 : load_0;
         d1_d = load_1 > 4'd9 ? 4'd9 : load_1;
         d2_d = load_2 > 4'd5 ? 4'd5 : load_2;
         d3_d = load_3 > 4'd9 ? 4'd9 : load_3;
         state_d = IDLE;
         ps_d = '0;
      end else if (stop) begin
         state_d = state_q == RUN ? PAUSE : state_q;
      end else if (start && state_q == IDLE && !zero) begin
         state_d = RUN;
         ps_d = '0;
      end else if (start && state_q == PAUSE) begin
         state_d = RUN;
      end else if (state_q == RUN) begin
         ps_d = tick ? '0 : ps_q + 1'b1;
         if (tick) begin
            d0_d = n0;
            d1_d = n1;
            d2_d = n2;
            d3_d = n3;
            state_d = next_zero ? DONE : RUN;
            done_d = next_zero;
         end
      end
   end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         ps_q <= '0;
         done_q <= 1'b0;
         d0_q <= 4'd0;
         d1_q <= 4'd0;
         d2_q <= 4'd0;
         d3_q <= 4'd0;
      end else begin
         state_q <= state_d;
         ps_q <= ps_d;
         done_q <= done_d;
         d0_q <= d0_d;
         d1_q <= d1_d;
         d2_q <= d2_d;
         d3_q <= d3_d;
      end
   end
   assign counter_0 = d0_q;
   assign counter_1 = d1_q;
   assign counter_2 = d2_q;
   assign counter_3 = d3_q;
   assign running = state_q == RUN;
   assign done = done_q;
endmodule

// File: tb/tb_countdown_counter.sv
// tb_countdown_counter: directed checks of the BCD countdown with PRESCALE=1 and PRESCALE=3 instances
module tb_countdown_counter;
   logic CLK = 1'b0, RST = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
   logic [3:0] load_0 = '0, load_1 = '0, load_2 = '0, load_3 = '0;
   logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
   logic a_run, a_done, b_run, b_done;
   int checks = 0, errors = 0;
   countdown_counter #(.PRESCALE(1), .PS_W(16)) u1 (
      .CLK(CLK), .RST(RST), .load(load), .load_0(load_0), .load_1(load_1),
      .load_2(load_2), .load_3(load_3), .start(start), .stop(stop),
      .counter_0(a0), .counter_1(a1), .counter_2(a2), .counter_3(a3),
      .running(a_run), .done(a_done));
   countdown_counter #(.PRESCALE(3), .PS_W(16)) u3 (
      .CLK(CLK), .RST(RST), .load(load), .load_0(load_0), .load_1(load_1),
      .load_2(load_2), .load_3(load_3), .start(start), .stop(stop),
      .counter_0(b0), .counter_1(b1), .counter_2(b2), .counter_3(b3),
      .running(b_run), .done(b_done));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   // digit weights: d0 x1, d1 x10, d2 x100 (0-5), d3 x600
   function automatic logic [15:0] bcd(input int n);
      return {4'(n / 600), 4'((n / 100) % 6), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic preset(input logic [3:0] v3, v2, v1, v0);
      {load_3, load_2, load_1, load_0} = {v3, v2, v1, v0};
      load = 1'b1;
      step();
      load = 1'b0;
   endtask
   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask
   initial begin
      #1;
      chk("reset_a", {a3, a2, a1, a0, 2'b0, a_run, a_done}, 18'h0);
      chk("reset_b", {b3, b2, b1, b0}, 16'h0);
      step();
      RST = 1'b1;
      step();
      preset(4'd0, 4'd1, 4'd0, 4'd0);
      chk("load_0100", {a3, a2, a1, a0}, 16'h0100);
      pulse_start();
      chk("start_run", {15'b0, a_run}, 16'h1);
      chk("start_nostep", {a3, a2, a1, a0}, 16'h0100);
      step();
      chk("borrow", {a3, a2, a1, a0}, bcd(99));
      for (int n = 98; n >= 1; n--) begin
         step();
         chk("seq", {a3, a2, a1, a0}, bcd(n));
      end
      chk("done_low_0001", {15'b0, a_done}, 16'h0);
      step();
      chk("zero", {a3, a2, a1, a0}, 16'h0);
      chk("done_pulse", {14'b0, a_run, a_done}, 16'h1);
      step();
      chk("done_gone", {14'b0, a_run, a_done}, 16'h0);
      pulse_start();
      chk("start_in_done", {a3, a2, a1, a0, 2'b0, a_run, a_done}, 18'h0);
      preset(4'd1, 4'd0, 4'd0, 4'd0);
      pulse_start();
      chk("ps3_run", {15'b0, b_run}, 16'h1);
      step();
      step();
      chk("ps3_hold2", {b3, b2, b1, b0}, bcd(600));
      step();
      chk("ps3_first", {b3, b2, b1, b0}, bcd(599));
      repeat (3) step();
      chk("ps3_second", {b3, b2, b1, b0}, bcd(598));
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("paused", {15'b0, b_run}, 16'h0);
      repeat (10) step();
      chk("pause_hold", {b3, b2, b1, b0}, bcd(598));
      start = 1'b1;
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_wins", {15'b0, b_run}, 16'h0);
      step();
      start = 1'b0;
      chk("resume", {b3, b2, b1, b0, 3'b0, b_run}, {bcd(598), 4'h1});
      step();
      chk("resume_held", {b3, b2, b1, b0}, bcd(598));
      step();
      chk("resume_step", {b3, b2, b1, b0}, bcd(597));
      {load_3, load_2, load_1, load_0} = 16'h0357;
      {load, stop, start} = 3'b111;
      step();
      {load, stop, start} = 3'b000;
      chk("prio_load", {b3, b2, b1, b0, 3'b0, b_run}, 20'h03570);
      pulse_start();
      step();
      chk("mid_run", {15'b0, b_run}, 16'h1);
      #2 RST = 1'b0;
      #1;
      chk("async_rst", {b3, b2, b1, b0, 2'b0, b_run, b_done}, 18'h0);
      step();
      RST = 1'b1;
      preset(4'd10, 4'd7, 4'd15, 4'd12);
      chk("saturate", {a3, a2, a1, a0}, 16'h9599);
      preset(4'd0, 4'd0, 4'd0, 4'd0);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         chk("zero_start", {a3, a2, a1, a0, 2'b0, a_run, a_done}, 18'h0);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
